// File: rtl/fpu_seq.sv
// fpu_seq: sequences commands onto an external combinational bfloat16 FPU, optional multiply-accumulate.
// Define FPU_SEQ_MAC_EN to build in the ACC state, the accumulator and acc_o.
module fpu_seq (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [3:0]  cmd_op_i,
    input  logic [15:0] cmd_a_i,
    input  logic [15:0] cmd_b_i,
    input  logic        cmd_mac_i,
    input  logic        acc_clr_i,
    output logic [3:0]  fpu_op_o,
    output logic [15:0] fpu_in1_o,
    output logic [15:0] fpu_in2_o,
    input  logic [15:0] fpu_out_i,
    input  logic        fpu_overflow_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [15:0] rsp_data_o,
    output logic        rsp_overflow_o,
    output logic [15:0] acc_o,
    output logic        busy_o
);
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_MUL = 4'b0001;

    typedef enum logic [1:0] {IDLE, ISSUE, ACC, RESP} state_t;

    state_t      state, state_nxt;
    logic [3:0]  op_q;
    logic [15:0] a_q, b_q, res_q;
    logic        mac_q, ovf_q, mac_en;

`ifdef FPU_SEQ_MAC_EN
    logic [15:0] acc_q;
    assign mac_en = cmd_mac_i;
    assign acc_o  = acc_q;
    // a clear coinciding with the ACC write wins; the response still carries the sum
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni)
            acc_q <= '0;
        else if (acc_clr_i)
            acc_q <= '0;
        else if (state == ACC)
            acc_q <= fpu_out_i;
`else
    logic unused_mac;
    assign unused_mac = ^{cmd_mac_i, acc_clr_i};
    assign mac_en     = 1'b0;
    assign acc_o      = '0;
`endif

    // gated by rst_ni so ready stays low while reset is held
    assign cmd_ready_o    = (state == IDLE) && rst_ni;
    assign busy_o         = state != IDLE;
    assign rsp_valid_o    = state == RESP;
    assign rsp_data_o     = res_q;
    assign rsp_overflow_o = ovf_q;

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            state <= IDLE;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            mac_q <= 1'b0;
            res_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (cmd_valid_i && cmd_ready_o) begin
                op_q  <= cmd_op_i;
                a_q   <= cmd_a_i;
                b_q   <= cmd_b_i;
                mac_q <= mac_en;
            end
            if (state == ISSUE) begin
                res_q <= fpu_out_i;
                ovf_q <= fpu_overflow_i;
            end
            if (state == ACC) begin
                res_q <= fpu_out_i;
                ovf_q <= ovf_q | fpu_overflow_i;
            end
        end

    always_comb begin
        state_nxt = state;
        fpu_op_o  = '0;
        fpu_in1_o = '0;
        fpu_in2_o = '0;
        case (state)
            IDLE: state_nxt = cmd_valid_i ? ISSUE : IDLE;
            ISSUE: begin
                fpu_op_o  = mac_q ? OP_MUL : op_q;
                fpu_in1_o = a_q;
                fpu_in2_o = b_q;
                state_nxt = mac_q ? ACC : RESP;
            end
            ACC: begin
                fpu_op_o  = OP_ADD;
                fpu_in1_o = res_q;
                fpu_in2_o = acc_o;
                state_nxt = RESP;
            end
            default: state_nxt = rsp_ready_i ? IDLE : RESP;
        endcase
    end
endmodule

// File: tb/tb_fpu_seq.sv
// tb_fpu_seq: directed vectors with a scoreboard queue and a response monitor for fpu_seq.
module tb_fpu_seq;
    logic        clk_i = 1'b0, rst_ni = 1'b0;
    logic        cmd_valid_i = 1'b0, cmd_ready_o;
    logic [3:0]  cmd_op_i = '0;
    logic [15:0] cmd_a_i = '0, cmd_b_i = '0;
    logic        cmd_mac_i = 1'b0, acc_clr_i = 1'b0;
    logic [3:0]  fpu_op_o;
    logic [15:0] fpu_in1_o, fpu_in2_o, fpu_out_i;
    logic        fpu_overflow_i;
    logic        rsp_valid_o, rsp_ready_i = 1'b1, rsp_overflow_o, busy_o;
    logic [15:0] rsp_data_o, acc_o;

    fpu_seq dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_op_i(cmd_op_i), .cmd_a_i(cmd_a_i), .cmd_b_i(cmd_b_i),
        .cmd_mac_i(cmd_mac_i), .acc_clr_i(acc_clr_i),
        .fpu_op_o(fpu_op_o), .fpu_in1_o(fpu_in1_o), .fpu_in2_o(fpu_in2_o),
        .fpu_out_i(fpu_out_i), .fpu_overflow_i(fpu_overflow_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_data_o(rsp_data_o), .rsp_overflow_o(rsp_overflow_o),
        .acc_o(acc_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // FPU stand-in: hand-computed bfloat16 results for the operand pairs used, xor otherwise
    function automatic logic [16:0] fpu_model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        case ({op, a, b})
            {4'h0, 16'h3F80, 16'h4000}: return {1'b0, 16'h4040};
            {4'h1, 16'h4000, 16'h4040}: return {1'b0, 16'h40C0};
            {4'h0, 16'h40C0, 16'h0000}: return {1'b0, 16'h40C0};
            {4'h1, 16'h3F80, 16'h4000}: return {1'b0, 16'h4000};
            {4'h0, 16'h4000, 16'h40C0}: return {1'b0, 16'h4100};
            {4'h0, 16'h4000, 16'h4100}: return {1'b0, 16'h4120};
            {4'h1, 16'h7F00, 16'h7F00}: return {1'b1, 16'h7F80};
            {4'h0, 16'h7F80, 16'h0000}: return {1'b0, 16'h7F80};
            default: return {1'b0, a ^ b};
        endcase
    endfunction

    always_comb {fpu_overflow_i, fpu_out_i} = fpu_model(fpu_op_o, fpu_in1_o, fpu_in2_o);

    typedef struct {
        logic [15:0] data;
        logic        ovf;
        int          hs;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    exp_t cur;
    logic have = 1'b0, prev_v = 1'b0;
    always @(negedge clk_i) begin
        if (rsp_valid_o && !prev_v) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", {16'h0, rsp_data_o}, 32'hFFFF_FFFF);
                have = 1'b0;
            end else begin
                cur  = sb.pop_front();
                have = 1'b1;
                chk("rsp_data", rsp_data_o, cur.data);
                chk("rsp_ovf", rsp_overflow_o, cur.ovf);
                chk("rsp_latency", cyc - cur.hs, cur.lat);
            end
        end else if (rsp_valid_o && have)
            chk("rsp_hold", {rsp_overflow_o, rsp_data_o}, {cur.ovf, cur.data});
        prev_v = rsp_valid_o;
    end

    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input logic mac,
                         input logic [15:0] ed, input logic eo, input int lat, input bit push);
        int t = 0;
        @(negedge clk_i);
        cmd_valid_i = 1'b1;
        cmd_op_i = op;
        cmd_a_i = a;
        cmd_b_i = b;
        cmd_mac_i = mac;
        while (!cmd_ready_o && t < 20) begin
            @(negedge clk_i);
            t++;
        end
        if (!cmd_ready_o) chk("handshake_timeout", cmd_ready_o, 1);
        @(posedge clk_i);
        #1;
        if (push) sb.push_back('{ed, eo, cyc, lat});
        cmd_valid_i = 1'b0;
        cmd_mac_i = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge clk_i);
        while (busy_o && t < 20) begin
            @(negedge clk_i);
            t++;
        end
        chk("idle_timeout", busy_o, 0);
    endtask

    task automatic chk_all_zero(input string nm);
        chk(nm, {rsp_valid_o, rsp_overflow_o, busy_o, cmd_ready_o, rsp_data_o}, 0);
        chk({nm, "_fpu"}, {fpu_op_o, fpu_in1_o, fpu_in2_o}, 0);
        chk({nm, "_acc"}, acc_o, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t;
        repeat (2) @(negedge clk_i);
        chk_all_zero("reset_out");
        rst_ni = 1'b1;
        #1 chk("ready_after_reset", cmd_ready_o, 1);

        issue(4'h0, 16'h3F80, 16'h4000, 1'b0, 16'h4040, 1'b0, 1, 1);
        chk("issue_drive_add", {fpu_op_o, fpu_in1_o, fpu_in2_o}, {4'h0, 16'h3F80, 16'h4000});
        wait_idle();
        issue(4'h1, 16'h4000, 16'h4040, 1'b0, 16'h40C0, 1'b0, 1, 1);
        wait_idle();
        issue(4'h5, 16'h1234, 16'h5678, 1'b0, 16'h444C, 1'b0, 1, 1);
        chk("op_forward", fpu_op_o, 4'h5);
        wait_idle();
        chk("idle_fpu_zero", {fpu_op_o, fpu_in1_o, fpu_in2_o}, 0);
        issue(4'h1, 16'h7F00, 16'h7F00, 1'b0, 16'h7F80, 1'b1, 1, 1);
        wait_idle();

        rsp_ready_i = 1'b0;
        issue(4'h0, 16'h3F80, 16'h4000, 1'b0, 16'h4040, 1'b0, 1, 1);
        t = 0;
        while (!rsp_valid_o && t < 20) begin
            @(negedge clk_i);
            t++;
        end
        chk("stall_rsp_seen", rsp_valid_o, 1);
        repeat (5) begin
            @(negedge clk_i);
            chk("stall_state", {cmd_ready_o, busy_o, rsp_valid_o}, 3'b011);
            chk("stall_fpu_zero", {fpu_op_o, fpu_in1_o, fpu_in2_o}, 0);
        end
        rsp_ready_i = 1'b1;
        @(posedge clk_i);
        #1 chk("stall_release", {cmd_ready_o, busy_o, rsp_valid_o}, 3'b100);

`ifdef FPU_SEQ_MAC_EN
        @(negedge clk_i) acc_clr_i = 1'b1;
        @(negedge clk_i) acc_clr_i = 1'b0;
        chk("acc_cleared", acc_o, 0);
        issue(4'h0, 16'h4000, 16'h4040, 1'b1, 16'h40C0, 1'b0, 2, 1);
        chk("mac_forces_mul", fpu_op_o, 4'h1);
        @(posedge clk_i);
        #1 chk("acc_drive", {fpu_op_o, fpu_in1_o, fpu_in2_o}, {4'h0, 16'h40C0, 16'h0000});
        wait_idle();
        chk("acc_mac1", acc_o, 16'h40C0);
        issue(4'h1, 16'h3F80, 16'h4000, 1'b1, 16'h4100, 1'b0, 2, 1);
        wait_idle();
        chk("acc_mac2", acc_o, 16'h4100);
        issue(4'h1, 16'h3F80, 16'h4000, 1'b1, 16'h4120, 1'b0, 2, 1);
        @(posedge clk_i);
        #1 acc_clr_i = 1'b1;
        @(posedge clk_i);
        #1 acc_clr_i = 1'b0;
        chk("clr_wins", acc_o, 0);
        wait_idle();
        issue(4'h1, 16'h7F00, 16'h7F00, 1'b1, 16'h7F80, 1'b1, 2, 1);
        wait_idle();
        chk("acc_mac_ovf", acc_o, 16'h7F80);
        issue(4'h1, 16'h4000, 16'h4040, 1'b1, 16'h0, 1'b0, 2, 0);
        @(posedge clk_i);
        #1 chk("in_acc", {busy_o, fpu_op_o}, {1'b1, 4'h0});
`else
        issue(4'h0, 16'h3F80, 16'h4000, 1'b1, 16'h4040, 1'b0, 1, 1);
        chk("mac_ignored_op", fpu_op_o, 4'h0);
        @(negedge clk_i) acc_clr_i = 1'b1;
        @(negedge clk_i) acc_clr_i = 1'b0;
        wait_idle();
        chk("acc_tied_zero", acc_o, 0);
        issue(4'h1, 16'h4000, 16'h4040, 1'b1, 16'h0, 1'b0, 1, 0);
`endif
        rst_ni = 1'b0;
        #1 chk_all_zero("mid_reset_out");
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        #1 chk("ready_after_mid_reset", cmd_ready_o, 1);
        chk("acc_after_mid_reset", acc_o, 0);
        repeat (6) @(negedge clk_i);
        chk("no_rsp_after_reset", {rsp_valid_o, busy_o}, 0);
        chk("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/fpu_seq.md
FPU_SEQ -- requirements
Module: fpu_seq

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset: clk_i  in  1  rising-edge clock; rst_ni  in  1  asynchronous active-low reset.
REQ-002 cmd_valid_i  in  1  command offered; cmd_ready_o  out  1  command accepted when both are high at a clock edge.
REQ-003 cmd_op_i  in  4  operation code (OP_ADD=4'b0000, OP_MUL=4'b0001 per data_type_pkg; other codes forwarded unchanged).
REQ-004 cmd_a_i, cmd_b_i  in  16 each  bfloat16 operands.
REQ-005 cmd_mac_i  in  1  multiply-accumulate request; acc_clr_i  in  1  synchronous accumulator clear.
REQ-006 fpu_op_o  out  4, fpu_in1_o  out  16, fpu_in2_o  out  16  drive the combinational FPU; fpu_out_i  in  16, fpu_overflow_i  in  1  return its result.
REQ-007 rsp_valid_o  out  1, rsp_ready_i  in  1  response handshake; rsp_data_o  out  16  result; rsp_overflow_o  out  1  overflow of that result.
REQ-008 acc_o  out  16  current accumulator value; busy_o  out  1  high in any state other than IDLE.

Function
REQ-009 The FSM SHALL have exactly the states IDLE, ISSUE, ACC and RESP.
REQ-010 cmd_ready_o SHALL be high only in IDLE; a handshake in cycle N captures op, operands and the mac bit into registers and moves to ISSUE.
REQ-011 In ISSUE the module SHALL drive fpu_op_o/fpu_in1_o/fpu_in2_o from the captured registers and register fpu_out_i and fpu_overflow_i at the end of that cycle.
REQ-012 ISSUE with mac=0 SHALL go to RESP; rsp_valid_o rises in cycle N+2.
REQ-013 ISSUE with mac=1 SHALL force fpu_op_o=OP_MUL regardless of cmd_op_i and go to ACC.
REQ-014 In ACC the module SHALL drive fpu_op_o=OP_ADD, fpu_in1_o=registered product, fpu_in2_o=accumulator, write the sum into the accumulator and the result register, then go to RESP; rsp_valid_o rises in cycle N+3.
REQ-015 For MAC, rsp_overflow_o SHALL be the OR of the multiply and add overflow flags.
REQ-016 In IDLE and RESP, fpu_op_o, fpu_in1_o and fpu_in2_o SHALL be 0.
REQ-017 In RESP, rsp_valid_o SHALL be high with rsp_data_o/rsp_overflow_o stable until rsp_ready_i is sampled high, then the FSM returns to IDLE; there is no back-to-back bypass.
REQ-018 acc_clr_i high at an edge SHALL set the accumulator to 16'h0000; if it coincides with the ACC write, the clear wins, and rsp_data_o still reports the computed sum.
REQ-019 Non-MAC operations SHALL leave the accumulator unchanged.

Reset
REQ-020 Reset assertion SHALL asynchronously force IDLE, the accumulator to 16'h0000, and all registered data to 0.
REQ-021 During reset, rsp_valid_o=0, rsp_data_o=0, rsp_overflow_o=0, busy_o=0, cmd_ready_o=0, and all fpu_* outputs are 0.
REQ-022 The first cycle after deassertion SHALL have cmd_ready_o=1.
REQ-023 A reset asserted mid-operation SHALL abandon the command with no response.

Configuration
REQ-024 The macro FPU_SEQ_MAC_EN SHALL compile in the ACC state, the accumulator and acc_o.
REQ-025 Without FPU_SEQ_MAC_EN, cmd_mac_i and acc_clr_i are ignored, ACC is unreachable, acc_o is tied to 16'h0000, and every command takes the N+2 path.

Verification
REQ-026 ADD 0x3F80+0x4000 handshake at N -> rsp_valid_o at N+2, rsp_data_o=0x4040, rsp_overflow_o=0.
REQ-027 MUL 0x4000*0x4040 -> rsp_data_o=0x40C0 at N+2.
REQ-028 With FPU_SEQ_MAC_EN, after acc_clr_i: MAC 0x4000*0x4040 -> response at N+3 = 0x40C0, acc_o=0x40C0; then MAC 0x3F80*0x4000 -> 0x4100.
REQ-029 MUL 0x7F00*0x7F00 -> rsp_overflow_o=1.
REQ-030 Hold rsp_ready_i low for 5 cycles in RESP -> rsp_data_o stable, cmd_ready_o=0, busy_o=1; raising rsp_ready_i -> IDLE the next cycle.
REQ-031 Assert rst_ni low during ACC -> all outputs 0 immediately, no response, acc_o=0x0000 after release.
